// File: rtl/rx_mass_check_if.sv
// rx_mass_check_if: RX byte stream in, TX 32-bit report stream out
interface rx_mass_check_if;
    logic        i_tready;
    logic        i_tvalid;
    logic [7:0]  i_tdata;
    logic        o_tready;
    logic        o_tvalid;
    logic [31:0] o_tdata;
    logic [3:0]  o_tkeep;
    logic        o_tlast;
    modport slave (
        input  i_tvalid, i_tdata, o_tready,
        output i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast
    );
    modport master (
        output i_tvalid, i_tdata, o_tready,
        input  i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast
    );
endinterface

// File: rtl/rx_mass_check.sv
// rx_mass_check: length-prefixed RX payload counter/pattern checker with 2-word report; RX_MASS_CHECK_PATTERN_EN enables pattern compare
module rx_mass_check #(
    parameter logic [7:0]  PATTERN_INIT   = 8'h00,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
    input  logic clk,
    input  logic rstn,
    rx_mass_check_if.slave s,
    output logic busy,
    output logic err
);
    typedef enum logic [1:0] {S_LEN, S_DATA, S_RPT0, S_RPT1} state_t;
    state_t state, nxt;
    logic [1:0]  hdr_idx;
    logic [31:0] len, rx_cnt, idle_cnt;
    logic [30:0] mism_cnt;
    logic        to_flag, acc, hs, last_byte, timeout;
    assign acc       = s.i_tvalid & s.i_tready;
    assign hs        = s.o_tvalid & s.o_tready;
    assign last_byte = acc && (rx_cnt + 32'd1 == len);
    assign timeout   = (TIMEOUT_CYCLES != 32'd0) && !acc && (idle_cnt == TIMEOUT_CYCLES - 32'd1);
    // next-state selection
    always_comb begin
        nxt = state;
        case (state)
            S_LEN:   if (acc && hdr_idx == 2'd3) nxt = ({s.i_tdata, len[23:0]} == 32'd0) ? S_RPT0 : S_DATA;
            S_DATA:  if (last_byte || timeout) nxt = S_RPT0;
            S_RPT0:  if (hs) nxt = S_RPT1;
            S_RPT1:  if (hs) nxt = S_LEN;
            default: nxt = S_LEN;
        endcase
    end
    // state register; i_tready is registered from the next state so no extra beat slips in
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_LEN;
            s.i_tready <= 1'b0;
        end else begin
            state      <= nxt;
            s.i_tready <= (nxt == S_LEN) || (nxt == S_DATA);
        end
    end
    // header capture, byte/idle counting, timeout flag, busy/err bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdr_idx  <= '0;
            len      <= '0;
            rx_cnt   <= '0;
            idle_cnt <= '0;
            to_flag  <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (state == S_LEN && acc) begin
                len[{hdr_idx, 3'b000} +: 8] <= s.i_tdata;
                hdr_idx <= hdr_idx + 2'd1;
                if (hdr_idx == 2'd0) begin
                    busy     <= 1'b1;
                    err      <= 1'b0;
                    rx_cnt   <= '0;
                    idle_cnt <= '0;
                    to_flag  <= 1'b0;
                end
            end
            if (state == S_DATA) begin
                if (acc) begin
                    rx_cnt   <= rx_cnt + 32'd1;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 32'd1;
                    if (timeout) to_flag <= 1'b1;
                end
            end
            if (state == S_RPT1 && hs) begin
                busy <= 1'b0;
                err  <= to_flag | (mism_cnt != 31'd0);
            end
        end
    end
`ifdef RX_MASS_CHECK_PATTERN_EN
    // saturating mismatch counter against the incrementing pattern
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mism_cnt <= '0;
        else if (state == S_LEN && acc && hdr_idx == 2'd0) mism_cnt <= '0;
        else if (state == S_DATA && acc && s.i_tdata != PATTERN_INIT + rx_cnt[7:0] && mism_cnt != '1)
            mism_cnt <= mism_cnt + 31'd1;
    end
`else
    logic unused_pattern;
    assign unused_pattern = ^PATTERN_INIT;
    assign mism_cnt = '0;
`endif
    assign s.o_tvalid = (state == S_RPT0) || (state == S_RPT1);
    assign s.o_tlast  = state == S_RPT1;
    assign s.o_tkeep  = 4'hF;
    assign s.o_tdata  = (state == S_RPT0) ? rx_cnt : (state == S_RPT1) ? {to_flag, mism_cnt} : 32'd0;
endmodule

// File: tb/tb_rx_mass_check.sv
// tb_rx_mass_check: directed + randomized checks of rx_mass_check against a queue-based reference
module tb_rx_mass_check;
    localparam logic [7:0] PI = 8'h00;
    localparam int TO = 16;
    logic clk = 1'b0, rstn = 1'b0, busy, err;
    int total = 0, bad = 0;
    logic [7:0] pay[$];
    rx_mass_check_if m();
    rx_mass_check #(.PATTERN_INIT(PI), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn), .s(m), .busy(busy), .err(err)
    );
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        m.i_tvalid = 1'b0;
        repeat (gap) @(negedge clk);
        m.i_tvalid = 1'b1;
        m.i_tdata  = b;
        while (!m.i_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_bound", 32'(n < 100), 32'd1);
        @(negedge clk);
        m.i_tvalid = 1'b0;
        m.i_tdata  = 8'($urandom);
    endtask

    task automatic recv(input string tag, input logic [31:0] w_exp, input logic last_exp, input int stall_max);
        int n = 0;
        logic [31:0] w;
        while (!m.o_tvalid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_bound"}, 32'(n < 1000), 32'd1);
        w = m.o_tdata;
        repeat ($urandom_range(0, stall_max)) begin
            m.o_tready = 1'b0;
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(m.o_tvalid), 32'd1);
            check({tag, "_stall_stable"}, m.o_tdata, w);
        end
        check(tag, m.o_tdata, w_exp);
        check({tag, "_last"}, 32'(m.o_tlast), 32'(last_exp));
        check({tag, "_keep"}, 32'(m.o_tkeep), 32'hF);
        m.o_tready = 1'b1;
        @(negedge clk);
    endtask

    task automatic make(input int n, input int nerr);
        pay.delete();
        for (int k = 0; k < n; k++) pay.push_back(8'(PI + k));
        repeat (nerr) begin
            int idx = $urandom_range(0, n - 1);
            pay[idx] = pay[idx] ^ 8'($urandom_range(1, 255));
        end
    endtask

    task automatic do_cmd(input string tag, input logic [31:0] n, input int maxgap, input int stall,
                          input int hdr_pause, input bit exp_to);
        int mm = 0;
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            send(8'(n >> (8 * i)), 0);
            if (i == 0) begin
                check({tag, "_busy_set"}, 32'(busy), 32'd1);
                check({tag, "_err_clr"}, 32'(err), 32'd0);
            end
            if (i == 1 && hdr_pause > 0) begin
                repeat (hdr_pause) @(negedge clk);
                check({tag, "_partial_novalid"}, 32'(m.o_tvalid), 32'd0);
                check({tag, "_partial_busy"}, 32'(busy), 32'd1);
                check({tag, "_partial_ready"}, 32'(m.i_tready), 32'd1);
            end
        end
        foreach (pay[k]) send(pay[k], $urandom_range(0, maxgap));
`ifdef RX_MASS_CHECK_PATTERN_EN
        foreach (pay[k]) if (pay[k] != 8'(PI + k)) mm++;
`endif
        if (exp_to) begin
            while (!m.o_tvalid && c < 100) begin
                @(negedge clk);
                c++;
            end
            check({tag, "_timeout_cycles"}, 32'(c), 32'(TO));
        end else begin
            check({tag, "_report_latency"}, 32'(m.o_tvalid), 32'd1);
        end
        check({tag, "_rdy_off"}, 32'(m.i_tready), 32'd0);
        recv({tag, "_w0"}, 32'(pay.size()), 1'b0, stall);
        recv({tag, "_w1"}, {exp_to, 31'(mm)}, 1'b1, stall);
        m.o_tready = 1'b0;
        check({tag, "_valid_drop"}, 32'(m.o_tvalid), 32'd0);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(exp_to || mm != 0));
        check({tag, "_rdy_on"}, 32'(m.i_tready), 32'd1);
    endtask

    initial begin
        m.i_tvalid = 1'b0;
        m.i_tdata  = 8'h00;
        m.o_tready = 1'b0;
        @(negedge clk);
        check("rst_i_tready", 32'(m.i_tready), 32'd0);
        check("rst_o_tvalid", 32'(m.o_tvalid), 32'd0);
        check("rst_o_tdata", m.o_tdata, 32'd0);
        check("rst_o_tlast", 32'(m.o_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rstn = 1'b1;
        #1 check("rel_i_tready", 32'(m.i_tready), 32'd0);
        @(negedge clk);
        check("first_clk_i_tready", 32'(m.i_tready), 32'd1);

        pay = '{8'h00, 8'h01, 8'h02, 8'h03};
        do_cmd("t1", 32'd4, 0, 0, 0, 1'b0);
        pay = '{8'h00, 8'hFF, 8'h02};
        do_cmd("t2", 32'd3, 0, 0, 0, 1'b0);
        pay.delete();
        do_cmd("t3", 32'd0, 0, 0, 0, 1'b0);
        make(5, 0);
        do_cmd("t4", 32'd10, 0, 0, 0, 1'b1);
        make(300, 0);
        do_cmd("t5", 32'd300, 3, 3, 0, 1'b0);
        make(60, 5);
        do_cmd("t7", 32'd60, 2, 2, 30, 1'b0);

        for (int i = 0; i < 4; i++) send(8'(32'd10 >> (8 * i)), 0);
        for (int k = 0; k < 3; k++) send(8'(PI + k), 0);
        check("t6_busy_before", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("t6_rst_i_tready", 32'(m.i_tready), 32'd0);
        check("t6_rst_o_tvalid", 32'(m.o_tvalid), 32'd0);
        check("t6_rst_o_tdata", m.o_tdata, 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("t6_rel_i_tready", 32'(m.i_tready), 32'd1);
        pay = '{8'h00};
        do_cmd("t6", 32'd1, 0, 1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
